// File: rtl/barrel_shifter_pipe.sv
// Pipelined WIDTH-bit shifter/rotator (SLL/SRL/SRA/ROL/ROR), one stage per amount bit.
// Latency: AW cycles; a beat accepted at edge N shows on the output after edge N+AW-1.
// Backpressure: a stalled output freezes every stage and drops in_ready; results hold stable.
module barrel_shifter_pipe #(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // SRA by a partial amount keeps the original MSB in place, so each stage
    // can take its fill bit from its own input MSB and the sign survives.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                               input logic [2:0]       op,
                                               input int               sh);
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_SLL:  r = d << sh;
            OP_SRL:  r = d >> sh;
            OP_SRA:  r = $unsigned($signed(d) >>> sh);
            OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
            OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
            default: r = d;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] dat_q   [AW];
    logic [AW-1:0]    amt_q   [AW];
    logic [2:0]       op_q    [AW];
    logic [AW-1:0]    vld_q;

    logic [WIDTH-1:0] src_dat [AW];
    logic [WIDTH-1:0] nxt_dat [AW];
    logic [AW-1:0]    src_amt [AW];
    logic [2:0]       src_op  [AW];
    logic [AW-1:0]    src_vld;

    logic adv;

    assign out_valid = vld_q[AW-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    genvar k;
    generate
        for (k = 0; k < AW; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign src_dat[k] = in_data;
                assign src_amt[k] = in_amt;
                assign src_op[k]  = in_op;
                assign src_vld[k] = in_valid;
            end else begin : g_rest
                assign src_dat[k] = dat_q[k-1];
                assign src_amt[k] = amt_q[k-1];
                assign src_op[k]  = op_q[k-1];
                assign src_vld[k] = vld_q[k-1];
            end
            assign nxt_dat[k] = src_amt[k][k] ? step(src_dat[k], src_op[k], 1 << k)
                                              : src_dat[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < AW; i++) begin
                dat_q[i] <= '0;
                amt_q[i] <= '0;
                op_q[i]  <= '0;
            end
        end else if (adv) begin
            vld_q <= src_vld;
            for (int i = 0; i < AW; i++) begin
                dat_q[i] <= nxt_dat[i];
                amt_q[i] <= src_amt[i];
                op_q[i]  <= src_op[i];
            end
        end
    end

    assign out_data = dat_q[AW-1];
    assign out_zero = (dat_q[AW-1] == '0);
    assign out_err  = (op_q[AW-1] > OP_ROR);

endmodule
